// File: rtl/rename_stage_pkg.sv
// Shared widths, reset constants and small combinational helpers for the rename stage.
package rename_stage_pkg;

  localparam int unsigned PHYS_REGS      = 32;
  localparam int unsigned TAG_W          = $clog2(PHYS_REGS);
  localparam int unsigned NUM_SRC        = 3;
  localparam int unsigned NUM_DST        = 2;
  localparam int unsigned AREG_W         = 4;
  localparam int unsigned NUM_CONST_AREG = 4;
  localparam int unsigned NUM_RAT        = 2 ** AREG_W - NUM_CONST_AREG;
  localparam int unsigned OPND_W         = 9;
  localparam int unsigned RENAMED_OP_SZ  = 4 + 16 + NUM_SRC * OPND_W + NUM_DST * TAG_W;

  // Every physical tag is free after reset/flush except tag 0, the discard sink.
  localparam logic [PHYS_REGS-1:0] FREE_RESET = {{(PHYS_REGS - 1){1'b1}}, 1'b0};

  // Value of a constant architectural register; 2 and 3 expose the next PC.
  function automatic logic [7:0] const_operand(input logic [1:0] sel, input logic [15:0] pc);
    logic [15:0] next_pc;
    logic [7:0]  val;
    next_pc = pc + 16'd1;
    case (sel)
      2'd0:    val = 8'h00;
      2'd1:    val = 8'h01;
      2'd2:    val = next_pc[7:0];
      default: val = next_pc[15:8];
    endcase
    return val;
  endfunction

  // Index of the lowest set bit; 0 when none is set (tag 0 is never free).
  function automatic logic [TAG_W-1:0] lowest_set(input logic [PHYS_REGS-1:0] vec);
    logic [TAG_W-1:0] idx;
    idx = '0;
    for (int unsigned i = PHYS_REGS; i > 0; i--) begin
      if (vec[i-1]) idx = TAG_W'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// Physical-tag free list: bitmap, two cascaded lowest-first pickers and a live count.
module rename_stage_free_list
  import rename_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_first,
  input  logic             alloc_second,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic [TAG_W-1:0] first_tag,
  output logic [TAG_W-1:0] second_tag,
  output logic [TAG_W:0]   free_count
);

  logic [PHYS_REGS-1:0] bitmap;
  logic [PHYS_REGS-1:0] bitmap_next;
  logic [PHYS_REGS-1:0] without_first;

  // The second picker sees the bitmap with the first pick removed.
  assign first_tag     = lowest_set(bitmap);
  assign without_first = bitmap & ~(PHYS_REGS'(1) << first_tag);
  assign second_tag    = lowest_set(without_first);

  // Population count of the current bitmap.
  always_comb begin
    free_count = '0;
    for (int unsigned i = 0; i < PHYS_REGS; i++) begin
      free_count = free_count + (TAG_W + 1)'(bitmap[i]);
    end
  end

  // Allocations clear bits; a freed tag only becomes pickable from the next cycle.
  always_comb begin
    bitmap_next = bitmap;
    if (alloc_first)  bitmap_next[first_tag]  = 1'b0;
    if (alloc_second) bitmap_next[second_tag] = 1'b0;
    if (free_valid && (free_tag != '0)) bitmap_next[free_tag] = 1'b1;
  end

  // Bitmap register; flush restores the all-free state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap <= FREE_RESET;
    end else if (flush) begin
      bitmap <= FREE_RESET;
    end else begin
      bitmap <= bitmap_next;
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Rename stage: RAT, operand resolution, tag allocation and the registered output op.
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_opcode,
  input  logic [NUM_SRC*AREG_W-1:0]    in_src,
  input  logic [NUM_DST*AREG_W-1:0]    in_dst,
  input  logic [15:0]                  in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_opcode,
  output logic [15:0]                  out_pc,
  output logic [NUM_SRC*OPND_W-1:0]    out_src,
  output logic [NUM_DST*TAG_W-1:0]     out_dst,
  input  logic                         wb_valid,
  input  logic [TAG_W-1:0]             wb_tag,
  input  logic [7:0]                   wb_value,
  input  logic                         free_valid,
  input  logic [TAG_W-1:0]             free_tag,
  input  logic                         flush,
  input  logic [NUM_RAT*8-1:0]         arf_values
);

  logic                     rat_valid [NUM_RAT];
  logic [TAG_W-1:0]         rat_tag   [NUM_RAT];
  logic [7:0]               rat_value [NUM_RAT];

  logic [TAG_W:0]           free_count;
  logic [TAG_W-1:0]         first_tag;
  logic [TAG_W-1:0]         second_tag;
  logic [NUM_DST-1:0]       dst_needs;
  logic [AREG_W-1:0]        dst_idx [NUM_DST];
  logic [TAG_W-1:0]         dst_tag [NUM_DST];
  logic [TAG_W:0]           need_cnt;
  logic                     accept;
  logic                     alloc_first;
  logic                     alloc_second;
  logic [NUM_SRC*OPND_W-1:0] src_resolved;
  logic [NUM_DST*TAG_W-1:0]  dst_packed;
  logic [RENAMED_OP_SZ-1:0]  op_q;

  // Which destinations need a physical tag, and how many in total.
  always_comb begin
    need_cnt = '0;
    for (int unsigned d = 0; d < NUM_DST; d++) begin
      dst_idx[d]   = in_dst[d*AREG_W +: AREG_W] - AREG_W'(NUM_CONST_AREG);
      dst_needs[d] = in_dst[d*AREG_W +: AREG_W] >= AREG_W'(NUM_CONST_AREG);
      need_cnt     = need_cnt + (TAG_W + 1)'(dst_needs[d]);
    end
  end

  // A lone renamed destination takes the first pick, whichever slot it is in.
  always_comb begin
    dst_tag[0] = dst_needs[0] ? first_tag : '0;
    dst_tag[1] = '0;
    if (dst_needs[1]) dst_tag[1] = dst_needs[0] ? second_tag : first_tag;
    dst_packed = {dst_tag[1], dst_tag[0]};
  end

  assign in_ready     = (!out_valid || out_ready) && (free_count >= need_cnt) && !flush;
  assign accept       = in_valid && in_ready;
  assign alloc_first  = accept && (|dst_needs);
  assign alloc_second = accept && (&dst_needs);

  rename_stage_free_list u_free_list (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .alloc_first  (alloc_first),
    .alloc_second (alloc_second),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .first_tag    (first_tag),
    .second_tag   (second_tag),
    .free_count   (free_count)
  );

  // Source resolution against the pre-update RAT with same-cycle writeback bypass.
  always_comb begin
    src_resolved = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      logic [AREG_W-1:0] areg;
      logic [AREG_W-1:0] idx;
      areg = in_src[s*AREG_W +: AREG_W];
      idx  = areg - AREG_W'(NUM_CONST_AREG);
      if (areg < AREG_W'(NUM_CONST_AREG)) begin
        src_resolved[s*OPND_W +: OPND_W] = {1'b0, const_operand(areg[1:0], in_pc)};
      end else if (rat_valid[idx]) begin
        src_resolved[s*OPND_W +: OPND_W] = {1'b0, rat_value[idx]};
      end else if (wb_valid && (wb_tag == rat_tag[idx])) begin
        src_resolved[s*OPND_W +: OPND_W] = {1'b0, wb_value};
      end else begin
        src_resolved[s*OPND_W +: OPND_W] = {1'b1, {(8 - TAG_W){1'b0}}, rat_tag[idx]};
      end
    end
  end

  // RAT update: writeback capture first, rename writes last so they win (dst[1] over dst[0]).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_RAT; i++) begin
        rat_valid[i] <= 1'b1;
        rat_tag[i]   <= '0;
        rat_value[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_RAT; i++) begin
        rat_valid[i] <= 1'b1;
        rat_value[i] <= arf_values[i*8 +: 8];
      end
    end else begin
      for (int unsigned i = 0; i < NUM_RAT; i++) begin
        if (wb_valid && !rat_valid[i] && (rat_tag[i] == wb_tag)) begin
          rat_valid[i] <= 1'b1;
          rat_value[i] <= wb_value;
        end
      end
      if (accept) begin
        for (int unsigned d = 0; d < NUM_DST; d++) begin
          if (dst_needs[d]) begin
            rat_valid[dst_idx[d]] <= 1'b0;
            rat_tag[dst_idx[d]]   <= dst_tag[d];
          end
        end
      end
    end
  end

  // Output register: loads on accept, holds while stalled, drops on consume or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_q      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op_q      <= {in_opcode, in_pc, src_resolved, dst_packed};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign {out_opcode, out_pc, out_src, out_dst} = op_q;

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: reference model of RAT/free list plus an output scoreboard.
module tb_rename_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [11:0] in_src;
  logic [7:0]  in_dst;
  logic [15:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [15:0] out_pc;
  logic [26:0] out_src;
  logic [9:0]  out_dst;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [7:0]  wb_value;
  logic        free_valid;
  logic [4:0]  free_tag;
  logic        flush;
  logic [95:0] arf_values;

  always #5 clk = ~clk;

  rename_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_src     (in_src),
    .in_dst     (in_dst),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_pc     (out_pc),
    .out_src    (out_src),
    .out_dst    (out_dst),
    .wb_valid   (wb_valid),
    .wb_tag     (wb_tag),
    .wb_value   (wb_value),
    .free_valid (free_valid),
    .free_tag   (free_tag),
    .flush      (flush),
    .arf_values (arf_values)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] pc;
    logic [26:0] src;
    logic [9:0]  dst;
  } exp_t;

  exp_t        sb[$];
  logic        m_valid [16];
  logic [4:0]  m_tag   [16];
  logic [7:0]  m_val   [16];
  logic [31:0] m_free;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic [4:0] lowest(input logic [31:0] v);
    logic [4:0] r = '0;
    for (int i = 31; i >= 0; i--) if (v[i]) r = 5'(i);
    return r;
  endfunction

  function automatic logic [8:0] exp_src(input logic [3:0] a);
    logic [15:0] p;
    p = in_pc + 16'd1;
    if (a == 4'd0) return 9'h000;
    if (a == 4'd1) return 9'h001;
    if (a == 4'd2) return {1'b0, p[7:0]};
    if (a == 4'd3) return {1'b0, p[15:8]};
    if (m_valid[a]) return {1'b0, m_val[a]};
    if (wb_valid && (wb_tag == m_tag[a])) return {1'b0, wb_value};
    return {1'b1, 3'b000, m_tag[a]};
  endfunction

  task automatic model_reset(input logic [95:0] arf);
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = '0;
      m_val[i]   = (i >= 4) ? arf[(i-4)*8 +: 8] : 8'h00;
    end
    m_free = 32'hFFFF_FFFE;
    sb.delete();
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] d0, input logic [3:0] d1,
                       input logic [15:0] pc);
    in_valid  = 1'b1;
    in_opcode = op;
    in_src    = {s2, s1, s0};
    in_dst    = {d1, d0};
    in_pc     = pc;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    int         need;
    logic       ready;
    logic [4:0] t0, t1, tg0, tg1;
    logic       n0, n1;
    exp_t       e;
    #1;
    n0 = in_dst[3:0] >= 4'd4;
    n1 = in_dst[7:4] >= 4'd4;
    need = 0;
    if (n0) need++;
    if (n1) need++;
    ready = ((sb.size() == 0) || out_ready) && (popc(m_free) >= need) && !flush;
    check("in_ready", in_ready, ready);
    check("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("out_opcode", out_opcode, sb[0].op);
      check("out_pc", out_pc, sb[0].pc);
      check("out_src", out_src, sb[0].src);
      check("out_dst", out_dst, sb[0].dst);
    end
    if (flush) begin
      model_reset(arf_values);
    end else begin
      if ((sb.size() != 0) && out_ready) void'(sb.pop_front());
      if (in_valid && ready) begin
        t0  = lowest(m_free);
        t1  = lowest(m_free & ~(32'd1 << t0));
        tg0 = n0 ? t0 : 5'd0;
        tg1 = n1 ? (n0 ? t1 : t0) : 5'd0;
        e.op  = in_opcode;
        e.pc  = in_pc;
        e.src = {exp_src(in_src[11:8]), exp_src(in_src[7:4]), exp_src(in_src[3:0])};
        e.dst = {tg1, tg0};
      end
      if (wb_valid) begin
        for (int i = 4; i < 16; i++) begin
          if (!m_valid[i] && (m_tag[i] == wb_tag)) begin
            m_valid[i] = 1'b1;
            m_val[i]   = wb_value;
          end
        end
      end
      if (in_valid && ready) begin
        if (n0) begin m_free[tg0] = 1'b0; m_valid[in_dst[3:0]] = 1'b0; m_tag[in_dst[3:0]] = tg0; end
        if (n1) begin m_free[tg1] = 1'b0; m_valid[in_dst[7:4]] = 1'b0; m_tag[in_dst[7:4]] = tg1; end
        sb.push_back(e);
      end
      if (free_valid && (free_tag != 5'd0)) m_free[free_tag] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    in_valid   = 1'b0;
    in_opcode  = '0;
    in_src     = '0;
    in_dst     = '0;
    in_pc      = '0;
    out_ready  = 1'b1;
    wb_valid   = 1'b0;
    wb_tag     = '0;
    wb_value   = '0;
    free_valid = 1'b0;
    free_tag   = '0;
    flush      = 1'b0;
    arf_values = '0;
    rst_n      = 1'b0;
    model_reset('0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_src", out_src, 27'd0);
    check("rst_out_dst", out_dst, 10'd0);
    check("rst_out_pc_op", {out_opcode, out_pc}, 20'd0);
    rst_n = 1'b1;

    // First op: all RAT-backed sources read reset zero; pc+1 = 0x1300.
    drive(4'd1, 4'd4, 4'd5, 4'd2, 4'd6, 4'd7, 16'h12FF);
    step();
    check("a_src", out_src, 27'd0);
    check("a_dst", out_dst, {5'd2, 5'd1});

    // Same-cycle writeback of tag 1 bypasses into areg 6; areg 7 stays pending on tag 2.
    drive(4'd2, 4'd6, 4'd7, 4'd0, 4'd8, 4'd0, 16'h0100);
    wb_valid = 1'b1; wb_tag = 5'd1; wb_value = 8'h5A;
    step();
    wb_valid = 1'b0;
    check("b_bypass", out_src[8:0], 9'h05A);
    check("b_pending", out_src[17:9], {1'b1, 3'b000, 5'd2});
    check("b_dst", out_dst, {5'd0, 5'd3});

    // Drain every remaining tag.
    for (int n = 0; n < 40 && popc(m_free) >= 2; n++) begin
      drive(4'd3, 4'd6, 4'd7, 4'd8, 4'd4, 4'd5, 16'(n));
      step();
    end
    drive(4'd4, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10, 16'h0200);
    #1 check("empty_ready", in_ready, 1'b0);
    step();

    drive(4'd5, 4'd0, 4'd1, 4'd3, 4'd0, 4'd3, 16'h0300);
    step();
    check("discard_dst", out_dst, 10'd0);

    // Tag freed this cycle is not allocatable until the next one.
    drive(4'd6, 4'd4, 4'd5, 4'd6, 4'd10, 4'd0, 16'h0400);
    free_valid = 1'b1; free_tag = 5'd9;
    #1 check("free_same_cycle", in_ready, 1'b0);
    step();
    free_valid = 1'b0;
    step();
    check("freed_tag9", out_dst, {5'd0, 5'd9});

    // Three-cycle output stall.
    drive(4'd7, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 16'h0500);
    step();
    out_ready = 1'b0;
    drive(4'd8, 4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 16'h0600);
    #1 check("stall_ready", in_ready, 1'b0);
    repeat (3) step();
    check("stall_hold", out_opcode, 4'd7);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();

    // Flush while an op is held.
    drive(4'd9, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 16'h0700);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();
    arf_values[15:8] = 8'h33;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_drop", out_valid, 1'b0);
    out_ready = 1'b1;
    drive(4'd10, 4'd5, 4'd4, 4'd0, 4'd4, 4'd5, 16'h0800);
    step();
    check("flush_arf5", out_src[8:0], 9'h033);
    check("flush_alloc", out_dst, {5'd2, 5'd1});
    in_valid = 1'b0;

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom), 16'($urandom));
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_valid   = $urandom_range(0, 1) == 1;
      wb_tag     = 5'($urandom);
      wb_value   = 8'($urandom);
      free_valid = $urandom_range(0, 2) == 0;
      free_tag   = 5'($urandom);
      flush      = $urandom_range(0, 49) == 0;
      if (flush) arf_values = {$urandom, $urandom, $urandom};
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; free_valid = 1'b0; flush = 1'b0;
    repeat (3) step();

    // Asynchronous reset mid-stall drops the held op.
    drive(4'd11, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 16'h0900);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", out_valid, 1'b0);
    model_reset('0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
# rename_stage

Registered, handshaked rename stage for the micro-op pipeline. It owns the register alias table (RAT) and the physical-register free list, resolves constant, known-value and pending operands, and allocates up to NUM_DST physical tags per micro-op. Writebacks, commits and flushes update its state. It sits between micro-op decode and dispatch.

## Interface
- PHYS_REGS, 32: physical registers. TAG_W = $clog2(PHYS_REGS). Tag 0 is the discard sink and is never allocated.
- NUM_SRC, 3: source operands per micro-op.
- NUM_DST, 2: destination operands per micro-op.
- AREG_W, 4: architectural register index width. Indices 0-3 are constants, 4..2^AREG_W-1 are RAT-backed.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid / in_ready  in/out  1  micro-op handshake from decode.
- in_opcode  in  4  micro-op opcode.
- in_src  in  NUM_SRC*AREG_W  source architectural registers.
- in_dst  in  NUM_DST*AREG_W  destination architectural registers.
- in_pc  in  16  macro PC.
- out_valid / out_ready  out/in  1  renamed-op handshake to dispatch.
- out_opcode, out_pc  out  4, 16  passed through.
- out_src  out  NUM_SRC*9  per operand {pending, payload}. pending=0: payload is the value. pending=1: payload[TAG_W-1:0] is the tag, upper bits zero.
- out_dst  out  NUM_DST*TAG_W  allocated tags; 0 means discard.
- wb_valid, wb_tag, wb_value  in  1, TAG_W, 8  result writeback.
- free_valid, free_tag  in  1, TAG_W  commit returns a tag to the free list.
- flush  in  1  squash all speculative state.
- arf_values  in  (2^AREG_W-4)*8  committed architectural values, used on flush.

## Operation
- Constants: areg 0 → 0, areg 1 → 1, areg 2 → (pc+1)[7:0], areg 3 → (pc+1)[15:8]. All are pending=0.
- RAT-backed source:
  - If the entry is valid, output its value.
  - Else if wb_valid and wb_tag equals the entry alias in the same cycle, output wb_value (bypass).
  - Else output pending=1 with the alias.
- Allocation:
  - Each destination with areg ≥ 4 needs one tag. Destinations with areg < 4 get tag 0 and allocate nothing.
  - Tags are taken lowest-index-first from the free bitmap. The second tag is chosen from the bitmap with the first removed.
- Sources read the RAT before this op's destination updates.
- RAT update on accept: the entry becomes {valid=0, alias=tag}. If both destinations name the same areg, dst[1] wins; both tags are still allocated.
- Writeback: every RAT entry with valid=0 and alias==wb_tag becomes valid with wb_value. A rename write to the same entry in the same cycle wins.
- Free: set the free_tag bit. Freeing tag 0 is ignored. A tag freed this cycle cannot be allocated until the next cycle.
- Flush:
  - Highest priority.
  - Free bitmap → all ones, except bit 0.
  - RAT → all valid, loaded from arf_values.
  - out_valid → 0; the input op is not accepted.

## Timing
- Reset values:
  - out_valid=0, all other outputs 0.
  - RAT all valid with value 0.
  - Free bitmap all ones, except bit 0.
- in_ready = (!out_valid || out_ready) && free_count ≥ needed(in_dst) && !flush. It is combinational from current state and input.
- Accept (in_valid && in_ready) loads the output register on the next edge. Latency is one cycle.
- Output stall:
  - out_* hold stable while out_valid && !out_ready.
  - Back-to-back accepts at full throughput are allowed when out_ready=1.
- Free list empty: in_ready stays 0 for ops needing tags. Ops with only discard destinations still flow.
- flush and reset mid-stall both drop the held op.

## Structure
- constants.vh holds PHYS_REGS, RENAMED_OP_SZ (= 4+16+NUM_SRC*9+NUM_DST*TAG_W), and the constant-areg count (4).
- Sub-module free_list:
  - Contents: bitmap, two cascaded priority_enc, free count, alloc/free/flush ports.
  - RAT, resolve logic and the output register stay in rename_stage.

## Test plan
- Reset, then op src={4,5,2}, dst={6,7}, pc=0x12FF → out_src values {0,0,0x00}, out_dst={1,2}; RAT[6], RAT[7] become pending.
- Next op reads areg 6 while wb_tag=1, wb_value=0x5A in the same cycle → out_src shows pending=0, 0x5A (bypass).
- dst={0,3} with an empty free list → accepted; out_dst={0,0}.
- Exhaust all 31 tags → in_ready=0. free_tag=9 → one cycle later in_ready=1 and tag 9 is allocated.
- out_ready held 0 for 3 cycles → outputs stable, in_ready=0. Release → next op follows.
- flush during a stall with arf_values[areg 5]=0x33 → out_valid=0, free count=31, next read of areg 5 gives 0x33 with pending=0.
